psum_accumulator: RTL
=====================

# psum_accumulator

Final reduction and accumulation stage. It sits directly downstream of the level-3 adder tree, which presents two registered signed INT16 partial sums per cycle. The block adds the two lanes, then accumulates successive beats of one dot-product packet into a saturating signed accumulator. On the packet's last beat it emits one result word with status flags. No backpressure: the upstream tree cannot stall, so the block accepts a beat on every cycle `in_valid` is high.

## Interface
Parameters:
- `LANE_W`, default `` `INT16 `` (16): width of each signed input lane.
- `ACC_W`, default 32: signed accumulator and result width; must be ≥ `LANE_W`+2.
- `MAX_BEATS`, default 256: maximum beats per packet before forced close.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state and outputs.
- `in_sums`  input  2*`LANE_W`  two signed lanes; lane0 = [`LANE_W`-1:0], lane1 = upper half; connects to the adder tree `out_sums`.
- `in_valid`  input  1  beat qualifier, aligned with the adder-tree output register.
- `in_last`  input  1  marks the final beat of a packet; ignored when `in_valid`=0.
- `out_acc`  output  `ACC_W`  signed packet result; held between results.
- `out_valid`  output  1  single-cycle pulse per completed packet.
- `out_sat`  output  1  result was clipped during the packet; valid with `out_valid`.
- `out_err`  output  1  packet force-closed at `MAX_BEATS` with no `in_last`; valid with `out_valid`.

## Operation
- Stage 1 (S1): lane sum = sign-extended lane0 + lane1 at `LANE_W`+1 bits, registered together with valid and last.
- Stage 2 (S2): a two-state FSM, IDLE and ACC.
  - IDLE: no packet open. An S1 valid beat computes acc = 0 + laneSum. If that beat is last, the packet closes immediately; otherwise the FSM moves to ACC.
  - ACC: each S1 valid beat computes acc = acc + laneSum. A beat that is last, or that is the `MAX_BEATS`-th beat, closes the packet and returns the FSM to IDLE.
  - S1 invalid cycles hold the FSM state, acc, and the beat count.
- Arithmetic:
  - laneSum is sign-extended to `ACC_W`+1 bits; the sum is formed at `ACC_W`+1 bits.
  - If the sum exceeds the signed `ACC_W` range, it is clipped to max or min and a sticky per-packet sat flag is set.
  - Accumulation continues from the clipped value.
- Beat counter: a `$clog2(MAX_BEATS+1)`-bit counter, cleared when a packet closes.
  - Reaching `MAX_BEATS` without last: close the packet with `out_err`=1.
  - An `in_last` arriving on exactly the `MAX_BEATS`-th beat is a normal close (`out_err`=0).
- On close: `out_acc` is loaded with the final (clipped) acc, `out_sat` with the sticky flag, and `out_err` is set as above. `out_valid`=1 for exactly one cycle.
- Back-to-back packets: a beat arriving the cycle after a close starts a new packet from 0, with no bubble. Sticky sat and the counter reset at each close.

## Timing
- Reset values: `out_acc`=0, `out_valid`=0, `out_sat`=0, `out_err`=0; FSM=IDLE; acc, counter, sat and S1 registers all 0.
- Latency: last beat on input at cycle n gives `out_valid`=1 at cycle n+2.
- Throughput: one beat per cycle, sustained indefinitely.
- `out_sat` and `out_err` are updated only on a close and hold until the next close.
- `out_valid` is low on every other cycle.
- Reset mid-packet: the partial packet is discarded and no `out_valid` is produced for it. A reset pulse during the S1 stage also drops the in-flight beat.
- `in_last` with `in_valid`=0: no effect.

## Structure
- `LANE_W` defaults from `` `INT16 `` in `def.v`.
- Add `` `ACC32 `` (32) and the lane index macros (`index16_0`, `index16_1` already exist) to `def.v`. Use these; do not hard-code slices.
- A single module is sufficient. Factor the saturating add into one sub-module, `sat_add_s`, parameterised by width, which outputs the clipped sum and an overflow bit. It is reused by later accumulation stages.

## Test plan
- Single-beat packet: lanes (100, −30), valid+last at cycle n → `out_valid` at n+2, `out_acc`=70, sat=0, err=0.
- Four-beat packet with gaps: lane pairs (1,2), (3,4), (−5,−6), (7,8), with `in_valid` low between beats → `out_acc`=14, one `out_valid` pulse.
- Back-to-back packets: packet A (10,10) last, then packet B (1,1) last on the next cycle → two consecutive pulses, 20 then 2; B is not contaminated by A.
- Saturation: 3 beats of (32767, 32767) with `ACC_W`=17 → `out_acc`=65535, `out_sat`=1.
  - The following packet (1,0) → `out_acc`=1, `out_sat`=0.
- Forced close: `MAX_BEATS`=4, 5 beats of (1,1) with no last → first pulse `out_acc`=8, `out_err`=1. The fifth beat opens a new packet.
- Reset mid-packet: 2 beats of (5,5), reset, then (1,2) last → a single `out_valid` with `out_acc`=3; all outputs read 0 during reset.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared constants and types for the partial-sum accumulation stage.
// Also consumed by later accumulation stages that reuse sat_add_s.
package psum_accumulator_pkg;

    localparam int INT16     = 16;
    localparam int ACC32     = 32;
    localparam int NUM_LANES = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/psum_accumulator_sat_add_s.sv
// Signed W-bit adder that clips to the W-bit signed range.
// Flags an overflow whenever clipping occurred.
module sat_add_s #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] wide;

    assign wide = (W+1)'(a) + (W+1)'(b);

    // The two top bits disagree only when the true sum left the W-bit range.
    always_comb begin
        ovf = wide[W] ^ wide[W-1];
        sum = wide[W-1:0];
        if (ovf) begin
            sum = wide[W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Final reduction stage: sums the two adder-tree lanes, then accumulates
// each packet into a saturating signed accumulator and emits one result.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int LANE_W    = INT16,
    parameter int ACC_W     = ACC32,
    parameter int MAX_BEATS = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES*LANE_W-1:0] in_sums,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic signed [ACC_W-1:0]     out_acc,
    output logic                        out_valid,
    output logic                        out_sat,
    output logic                        out_err
);

    localparam int SUM_W = LANE_W + 1;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    logic signed [SUM_W-1:0] lane_ext [NUM_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign lane_ext[gi] = {in_sums[gi*LANE_W + LANE_W - 1],
                                   in_sums[gi*LANE_W +: LANE_W]};
        end
    endgenerate

    logic signed [SUM_W-1:0] s1_sum_reg;
    logic                    s1_valid_reg;
    logic                    s1_last_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_sum_reg   <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else begin
            s1_sum_reg   <= lane_ext[0] + lane_ext[1];
            s1_valid_reg <= in_valid;
            s1_last_reg  <= in_valid & in_last;
        end
    end

    acc_state_t              state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    sat_reg, sat_next;
    logic                    close_next;
    logic                    err_next;
    logic                    sat_pkt;
    logic [CNT_W-1:0]        cnt_inc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum_ext;
    logic signed [ACC_W-1:0] sat_sum;
    logic                    sat_ovf;

    assign sum_ext  = ACC_W'(s1_sum_reg);
    assign acc_base = (state_reg == ST_IDLE) ? '0 : acc_reg;
    assign cnt_inc  = cnt_reg + 1'b1;

    sat_add_s #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc_base),
        .b   (sum_ext),
        .sum (sat_sum),
        .ovf (sat_ovf)
    );

    // A closing beat leaves acc, count and sticky flag cleared so the
    // very next beat starts a fresh packet with no bubble.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sat_next   = sat_reg;
        close_next = 1'b0;
        err_next   = 1'b0;
        sat_pkt    = ((state_reg == ST_ACC) & sat_reg) | sat_ovf;
        if (s1_valid_reg) begin
            close_next = s1_last_reg | (cnt_inc == MAX_CNT);
            err_next   = ~s1_last_reg & (cnt_inc == MAX_CNT);
            if (close_next) begin
                state_next = ST_IDLE;
                acc_next   = '0;
                cnt_next   = '0;
                sat_next   = 1'b0;
            end else begin
                state_next = ST_ACC;
                acc_next   = sat_sum;
                cnt_next   = cnt_inc;
                sat_next   = sat_pkt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
        end
    end

    // Result and flags only change on a close and are held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_acc   <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= close_next;
            if (close_next) begin
                out_acc <= sat_sum;
                out_sat <= sat_pkt;
                out_err <= err_next;
            end
        end
    end

endmodule
